// File: rtl/lc3_alu_pkg.sv
// lc3_alu_pkg: shared types and helpers for the LC-3 ALU pipeline stage.
//   alu_op_e    - 3-bit opcode as presented on alu_control
//   alu_state_e - control FSM states (IDLE empty, HOLD result held, MUL iterating)
//   NZP_*       - one-hot condition-code encodings {N,Z,P}
//   nzp_of()    - condition codes of a value of a given width (width <= 64)
package lc3_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_AND   = 3'd1,
    OP_NOT   = 3'd2,
    OP_PASSA = 3'd3,
    OP_SUB   = 3'd4,
    OP_XOR   = 3'd5,
    OP_SHL   = 3'd6,
    OP_MUL   = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_MUL  = 2'd2
  } alu_state_e;

  localparam logic [2:0] NZP_N = 3'b100;
  localparam logic [2:0] NZP_Z = 3'b010;
  localparam logic [2:0] NZP_P = 3'b001;

  localparam int NZP_MAX_W = 64;

  // Only the low 'width' bits of 'value' are considered.
  function automatic logic [2:0] nzp_of(input logic [NZP_MAX_W-1:0] value,
                                        input int width);
    logic [NZP_MAX_W-1:0] mask;
    logic                 sign;
    mask = ~({NZP_MAX_W{1'b1}} << width);
    sign = |(value & (NZP_MAX_W'(1) << (width - 1)));
    if ((value & mask) == '0) return NZP_Z;
    else if (sign)            return NZP_N;
    else                      return NZP_P;
  endfunction

endpackage

// File: rtl/lc3_alu_mul_seq.sv
// lc3_alu_mul_seq: unsigned shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   start     - load operands a/b and begin (only while not busy)
//   a, b      - WIDTH-bit unsigned operands
//   busy      - iteration in progress
//   done      - high during the final step; product is valid in that cycle
//   product   - 2*WIDTH-bit result, meaningful when done=1
// The run takes WIDTH cycles after the start edge; done is raised in the
// cycle whose closing edge retires the last multiplier bit.
module lc3_alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   count;

  // Product including the current step, so the top can capture it on the
  // same edge that finishes the run.
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign done     = busy & (count == CNT_W'(WIDTH - 1));
  assign product  = acc_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      count  <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done) begin
        busy  <= 1'b0;
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lc3_alu_pipe.sv
// lc3_alu_pipe: LC-3 ALU stage with registered result and valid/ready flow.
// Build option: define ALU_MUL_EN to make opcode 7 an iterative multiply;
// without it opcode 7 returns zero in one cycle and raises illegal.
// Ports:
//   clk, rst              - clock, asynchronous active-low reset
//   in_valid / in_ready   - operation handshake (alu_control, aluin1, aluin2)
//   out_valid / out_ready - result handshake (aluout, nzp, carry, illegal)
//   alu_control           - 0 ADD,1 AND,2 NOT,3 PASSA,4 SUB,5 XOR,6 SHL,7 MUL
//   aluout                - WIDTH-bit result
//   nzp                   - one-hot {N,Z,P} of aluout
//   carry                 - ADD carry-out, SUB no-borrow, SHL last bit out,
//                           MUL high-half nonzero; 0 otherwise
//   illegal               - opcode not supported in this build
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready depends only on state and out_ready (never on in_valid),
// and the producer must hold its op stable while in_valid=1 and in_ready=0.
// The result and out_valid stay stable while out_valid=1 and out_ready=0.
module lc3_alu_pipe
  import lc3_alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] aluin1,
  input  logic [WIDTH-1:0] aluin2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluout,
  output logic [2:0]       nzp,
  output logic             carry,
  output logic             illegal
);

  alu_state_e         state;
  alu_state_e         state_next;
  alu_op_e            op;
  logic               accept;
  logic               is_mul_op;
  logic               start_mul;

  logic [WIDTH-1:0]   res;
  logic               res_carry;
  logic               res_illegal;
  logic [WIDTH:0]     add_wide;
  logic [WIDTH:0]     shl_wide;
  logic [SHAMT_W-1:0] shamt;

  assign op        = alu_op_e'(alu_control);
  assign accept    = in_valid & in_ready;
`ifdef ALU_MUL_EN
  assign is_mul_op = (op == OP_MUL);
`else
  assign is_mul_op = 1'b0;
`endif
  assign start_mul = accept & is_mul_op;

`ifdef ALU_MUL_EN
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  lc3_alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (start_mul),
    .a       (aluin1),
    .b       (aluin2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  mul_busy_in_mul_state: assert property (
    @(posedge clk) disable iff (!rst) (state == ST_MUL) |-> mul_busy);
`endif

  // Single-cycle datapath. The shift keeps one bit above the result so that
  // bit WIDTH is the last bit shifted out (and 0 when shamt is 0).
  always_comb begin
    res         = '0;
    res_carry   = 1'b0;
    res_illegal = 1'b0;
    add_wide    = {1'b0, aluin1} + {1'b0, aluin2};
    shamt       = aluin2[SHAMT_W-1:0];
    shl_wide    = {1'b0, aluin1} << shamt;
    case (op)
      OP_ADD: begin
        res       = add_wide[WIDTH-1:0];
        res_carry = add_wide[WIDTH];
      end
      OP_AND:   res = aluin1 & aluin2;
      OP_NOT:   res = ~aluin1;
      OP_PASSA: res = aluin1;
      OP_SUB: begin
        res       = aluin1 - aluin2;
        res_carry = (aluin1 >= aluin2);
      end
      OP_XOR:   res = aluin1 ^ aluin2;
      OP_SHL: begin
        res       = shl_wide[WIDTH-1:0];
        res_carry = shl_wide[WIDTH];
      end
      OP_MUL: begin
`ifdef ALU_MUL_EN
        res_illegal = 1'b0;
`else
        res_illegal = 1'b1;
`endif
      end
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = start_mul ? ST_MUL : ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          if (!in_valid)      state_next = ST_IDLE;
          else if (start_mul) state_next = ST_MUL;
          else                state_next = ST_HOLD;
        end
      end
`ifdef ALU_MUL_EN
      ST_MUL: begin
        if (mul_done) state_next = ST_HOLD;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state == ST_IDLE) | ((state == ST_HOLD) & out_ready);
    out_valid = (state == ST_HOLD);
  end

  // Result registers. A MUL accept leaves them untouched; out_valid is low
  // until the product lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aluout  <= '0;
      nzp     <= NZP_Z;
      carry   <= 1'b0;
      illegal <= 1'b0;
    end else if (accept && !start_mul) begin
      aluout  <= res;
      nzp     <= nzp_of(NZP_MAX_W'(res), WIDTH);
      carry   <= res_carry;
      illegal <= res_illegal;
    end
`ifdef ALU_MUL_EN
    else if (mul_done) begin
      aluout  <= mul_product[WIDTH-1:0];
      nzp     <= nzp_of(NZP_MAX_W'(mul_product[WIDTH-1:0]), WIDTH);
      carry   <= |mul_product[2*WIDTH-1:WIDTH];
      illegal <= 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_lc3_alu_pipe.sv
`timescale 1ns/1ps
module tb_lc3_alu_pipe;

  localparam int    W   = 16;
  localparam longint MOD = 64'd65536;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   alu_control = 3'd0;
  logic [W-1:0] aluin1 = '0;
  logic [W-1:0] aluin2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] aluout;
  logic [2:0]   nzp;
  logic         carry;
  logic         illegal;

  int n_cmp = 0;
  int n_err = 0;
  logic [20:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  lc3_alu_pipe #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .aluin1      (aluin1),
    .aluin2      (aluin2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .aluout      (aluout),
    .nzp         (nzp),
    .carry       (carry),
    .illegal     (illegal)
  );

  // ---------------- reference model ----------------
  // Packs {illegal, carry, nzp, aluout}.
  function automatic logic [20:0] model(input int op, input longint a, input longint b);
    longint     r;
    longint     s;
    int         sh;
    logic       c;
    logic       il;
    logic [2:0] z;
    r  = 0;
    c  = 1'b0;
    il = 1'b0;
    case (op)
      0: begin s = a + b; r = s % MOD; c = (s >= MOD); end
      1: r = a & b;
      2: r = (MOD - 1) - a;
      3: r = a;
      4: begin r = (a - b + MOD) % MOD; c = (a >= b); end
      5: r = a ^ b;
      6: begin
        sh = int'(b % W);
        s  = a * (longint'(1) << sh);
        r  = s % MOD;
        c  = ((s / MOD) % 2) == 1;
      end
      default: begin
        if (MUL_EN) begin s = a * b; r = s % MOD; c = (s >= MOD); end
        else        il = 1'b1;
      end
    endcase
    if (r == 0)             z = 3'b010;
    else if (r >= MOD / 2)  z = 3'b100;
    else                    z = 3'b001;
    return {il, c, z, W'(r)};
  endfunction

  function automatic logic [20:0] observed();
    return {illegal, carry, nzp, aluout};
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_cmp++;
    if (obs !== expd) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expd, $time);
    end
  endtask

  // ---------------- drivers ----------------
  // Called just after a rising edge with the block idle; leaves it idle.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input string tag);
    int          edges;
    logic [20:0] expd;
    expd        = model(int'(op), longint'(a), longint'(b));
    alu_control = op;
    aluin1      = a;
    aluin2      = b;
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges    = 0;
    while (!out_valid && edges < 3 * W) begin
      check({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_latency"}, 32'(edges), (op == 3'd7 && MUL_EN) ? 32'(W) : 32'd0);
    check({tag, "_result"}, 32'(observed()), 32'(expd));
    @(posedge clk); #1;
    check({tag, "_idle_after"}, 32'(out_valid), 32'd0);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return W'(16'h8000);
      3:       return W'(16'h7FFF);
      default: return W'($urandom());
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [20:0] expd;
    logic        acc_last;
    logic        seen;

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_aluout",    32'(aluout),    32'd0);
    check("rst_nzp",       32'(nzp),       32'b010);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_carry",     32'(carry),     32'd0);
    check("rst_illegal",   32'(illegal),   32'd0);

    // directed single-cycle ops
    do_op(3'd0, 16'h7FFF, 16'h0001, "add_to_neg");
    do_op(3'd0, 16'hFFFF, 16'h0001, "add_carry");
    do_op(3'd4, 16'h0003, 16'h0005, "sub_borrow");
    do_op(3'd4, 16'h0005, 16'h0005, "sub_equal");
    do_op(3'd6, 16'h8001, 16'h0001, "shl_1");
    do_op(3'd6, 16'h1234, 16'h0000, "shl_0");
    do_op(3'd6, 16'h0001, 16'h000F, "shl_15");
    do_op(3'd2, 16'h00FF, 16'h0000, "not");
    do_op(3'd3, 16'h0000, 16'h1111, "passa_zero");
`ifdef ALU_MUL_EN
    do_op(3'd7, 16'h0012, 16'h0034, "mul_small");
    do_op(3'd7, 16'h0100, 16'h0100, "mul_ovf");
`else
    do_op(3'd7, 16'h0012, 16'h0034, "op7_illegal");
`endif
    do_op(3'd0, 16'h0001, 16'h0001, "add_after_op7");

    // back-pressure: XOR held for 5 cycles, then AND accepted on release
    alu_control = 3'd5; aluin1 = 16'hA5C3; aluin2 = 16'h0FF0;
    in_valid = 1'b1; out_ready = 1'b0;
    expd = model(5, 64'hA5C3, 64'h0FF0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready",  32'(in_ready),   32'd0);
      check("bp_out_valid", 32'(out_valid),  32'd1);
      check("bp_hold",      32'(observed()), 32'(expd));
      @(posedge clk); #1;
    end
    alu_control = 3'd1; aluin1 = 16'hF0F0; aluin2 = 16'h3C3C;
    in_valid = 1'b1; out_ready = 1'b1;
    expd = model(1, 64'hF0F0, 64'h3C3C);
    @(negedge clk);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_b2b_valid",  32'(out_valid),  32'd1);
    check("bp_b2b_result", 32'(observed()), 32'(expd));
    @(posedge clk); #1;

    // randomized streaming against the scoreboard
    acc_last = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (acc_last) in_valid = 1'b0;
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        alu_control = 3'($urandom_range(0, 7));
        aluin1      = pick_operand();
        aluin2      = pick_operand();
        in_valid    = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (out_valid && out_ready) begin
        check("rand_q_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) check("rand_result", 32'(observed()), 32'(exp_q.pop_front()));
      end
      acc_last = in_valid && in_ready;
      if (acc_last) exp_q.push_back(model(int'(alu_control), longint'(aluin1), longint'(aluin2)));
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3 * W && exp_q.size() != 0; i++) begin
      @(negedge clk);
      if (out_valid) check("drain_result", 32'(observed()), 32'(exp_q.pop_front()));
      @(posedge clk); #1;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    check("drain_idle", 32'(out_valid), 32'd0);

    // asynchronous reset while holding a result
    alu_control = 3'd0; aluin1 = 16'hFFFF; aluin2 = 16'h0001;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("hold_before_rst", 32'(out_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_aluout",    32'(aluout),    32'd0);
    check("async_rst_nzp",       32'(nzp),       32'b010);
    check("async_rst_carry",     32'(carry),     32'd0);
    check("async_rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

`ifdef ALU_MUL_EN
    // reset in the middle of a multiply: nothing must come out
    alu_control = 3'd7; aluin1 = 16'h0012; aluin2 = 16'h0034;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("mul_abort_no_output", 32'(seen), 32'd0);
    @(posedge clk); #1;
    check("mul_abort_in_ready", 32'(in_ready), 32'd1);
`else
    seen = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lc3_alu_pipe.md
Name: lc3_alu_pipe

Overview:
- Parametrised next-generation LC-3 ALU with a valid/ready handshake and a registered result.
- Adds SUB, XOR, PASSA, SHL, NZP condition codes and carry.
- Optional iterative multiplier.
- Sits between decode/register-read and writeback; one op in flight at a time.

Parameters:
- WIDTH, 16, operand/result width (≥4, power of 2).
- SHAMT_W, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- in_valid  input  1  operation presented
- in_ready  output  1  block accepts op this cycle
- alu_control  input  3  opcode: 0 ADD, 1 AND, 2 NOT, 3 PASSA, 4 SUB, 5 XOR, 6 SHL, 7 MUL
- aluin1  input  WIDTH  operand A
- aluin2  input  WIDTH  operand B; SHL uses aluin2[SHAMT_W-1:0]
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes result
- aluout  output  WIDTH  result
- nzp  output  3  {N,Z,P} of aluout, one-hot
- carry  output  1  carry/flag, see below
- illegal  output  1  op unsupported in this build

Behaviour:
- Reset (rst=0, async): state IDLE, out_valid=0, aluout=0, nzp=3'b010, carry=0, illegal=0, multiply counter=0. Reset mid-MUL abandons the op; nothing is output.
- FSM states: IDLE (empty), HOLD (result held), MUL (iterating).
- in_ready = (state==IDLE) | (state==HOLD & out_ready). It is 0 in MUL. It is combinational from out_ready only, never from in_valid.
- Accept = in_valid & in_ready. Operands and opcode are captured at the accept edge.
- Single-cycle ops (0-6): result registered at the accept edge; out_valid=1 the next cycle. Latency 1.
- Transitions:
  - IDLE→HOLD on accept.
  - HOLD→IDLE on out_ready & !in_valid.
  - HOLD→HOLD on out_ready & in_valid for a single-cycle op: back-to-back, full throughput, out_valid stays 1.
  - HOLD with !out_ready: all outputs stable.
- Arithmetic, modulo 2^WIDTH:
  - ADD a+b; carry = bit WIDTH of the sum.
  - SUB a-b; carry = 1 iff a≥b unsigned (no borrow).
  - SHL a<<shamt; carry = last bit shifted out, 0 if shamt=0.
  - AND, NOT(~a), PASSA(a), XOR: carry=0.
- nzp: N = aluout[WIDTH-1]; Z = (aluout==0); P otherwise. Updated together with aluout.
- MUL (ALU_MUL_EN defined):
  - Accept → state MUL, counter=0. One shift-add step per cycle.
  - At the edge where counter==WIDTH-1: →HOLD, aluout = low WIDTH bits of the unsigned product, carry = OR of the high WIDTH bits (overflow).
  - out_valid rises WIDTH cycles after the accept edge.
  - Accept of MUL from HOLD (with out_ready): out_valid drops next cycle until the product completes.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: opcode 7 = iterative multiply as above; illegal is always 0.
- Undefined: no MUL state or multiplier logic. Opcode 7 completes in 1 cycle with aluout=0, nzp=3'b010, carry=0, illegal=1. illegal is cleared by the next accepted legal op.

Decomposition:
- lc3_alu_pkg:
  - alu_op_e enum (ADD..MUL, 3-bit)
  - alu_state_e (IDLE, HOLD, MUL)
  - NZP_N/NZP_Z/NZP_P constants
  - function computing nzp from a WIDTH value
- Sub-module lc3_alu_mul_seq: start/busy/done shift-add multiplier with its counter. Instantiated only under ALU_MUL_EN.

Test Plan (WIDTH=16):
- Reset held low, then released → out_valid=0, aluout=0, nzp=010, in_ready=1. Assert rst low during HOLD → outputs return to reset values immediately (async).
- ADD 16'h7FFF+16'h0001, out_ready=1 → next cycle aluout=16'h8000, nzp=100, carry=0. ADD FFFF+0001 → aluout=0000, nzp=010, carry=1.
- SUB 0003-0005 → aluout=FFFE, nzp=100, carry=0. SHL 8001 by 1 → aluout=0002, carry=1.
- Back-pressure: XOR result with out_ready=0 for 5 cycles → in_ready=0, aluout/nzp stable. Then out_ready=1 with new AND op on the same cycle → updated result next cycle, out_valid never drops.
- ALU_MUL_EN: MUL 0012×0034 → in_ready=0 for 16 cycles, then aluout=03A8, carry=0. MUL 0100×0100 → aluout=0000, carry=1, nzp=010. Assert reset at cycle 8 → no output.
- Without ALU_MUL_EN: opcode 7 → 1-cycle result aluout=0, illegal=1. A following ADD 0001+0001 → aluout=0002, illegal=0.
